// File: rtl/instr_fetch_if.sv
// Fetch-unit bus bundle: memory read port plus the instruction stream toward the decoder.
// master = fetch unit, slave = memory and consumer side.
interface instr_fetch_if #(
    parameter int unsigned ADDR_W = 16,
    parameter int unsigned DATA_W = 16
);
    logic              mem_req;
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_ack;
    logic [DATA_W-1:0] mem_rdata;
    logic [DATA_W-1:0] instr;
    logic [ADDR_W-1:0] instr_pc;
    logic              instr_valid;
    logic              instr_ready;

    modport master (
        output mem_req,
        output mem_addr,
        input  mem_ack,
        input  mem_rdata,
        output instr,
        output instr_pc,
        output instr_valid,
        input  instr_ready
    );

    modport slave (
        input  mem_req,
        input  mem_addr,
        output mem_ack,
        output mem_rdata,
        input  instr,
        input  instr_pc,
        input  instr_valid,
        output instr_ready
    );
endinterface

// File: rtl/instr_fetch.sv
// Instruction fetch unit: sequential PC, redirect flush, small shift-on-pop instruction FIFO.
// FETCH_PREFETCH_EN defined -> two-entry FIFO (one fetch per cycle); undefined -> one entry.
module instr_fetch #(
    parameter int unsigned ADDR_W = 16,
    parameter int unsigned DATA_W = 16
) (
    input  logic              CLK,
    input  logic              reset,
    input  logic [ADDR_W-1:0] pc_reset_address,
    input  logic              redirect,
    input  logic [ADDR_W-1:0] redirect_addr,
    instr_fetch_if.master     bus,
    output logic [ADDR_W-1:0] pc
);

`ifdef FETCH_PREFETCH_EN
    localparam int unsigned DEPTH = 2;
`else
    localparam int unsigned DEPTH = 1;
`endif
    localparam int unsigned CNT_W = 2;

    logic [CNT_W-1:0]  count;
    logic [DATA_W-1:0] buf_data [DEPTH];
    logic [ADDR_W-1:0] buf_pc   [DEPTH];
    logic [DATA_W-1:0] nxt_data [DEPTH];
    logic [ADDR_W-1:0] nxt_pc   [DEPTH];

    logic              fetch_fire_c;
    logic              pop_c;
    logic [CNT_W-1:0]  wr_idx_c;

    // Reset gates the handshakes combinationally so nothing leaks out mid-reset.
    assign bus.mem_req     = (count < CNT_W'(DEPTH)) && !reset;
    assign bus.mem_addr    = pc;
    assign bus.instr_valid = (count != '0) && !reset;
    assign bus.instr       = buf_data[0];
    assign bus.instr_pc    = buf_pc[0];

    assign fetch_fire_c = bus.mem_req && bus.mem_ack;
    assign pop_c        = bus.instr_valid && bus.instr_ready;
    assign wr_idx_c     = count - CNT_W'(pop_c);

    // Next FIFO contents: shift toward the head on pop, then write the new word behind the survivors.
    always_comb begin
        nxt_data = buf_data;
        nxt_pc   = buf_pc;
        if (pop_c) begin
            for (int unsigned i = 1; i < DEPTH; i++) begin
                nxt_data[i-1] = buf_data[i];
                nxt_pc[i-1]   = buf_pc[i];
            end
        end
        if (fetch_fire_c) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                if (CNT_W'(i) == wr_idx_c) begin
                    nxt_data[i] = bus.mem_rdata;
                    nxt_pc[i]   = pc;
                end
            end
        end
    end

    // Priority: reset, then redirect (drops same-cycle ack and pop), then normal fetch/consume.
    always_ff @(posedge CLK) begin
        if (reset) begin
            pc    <= pc_reset_address;
            count <= '0;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                buf_data[i] <= '0;
                buf_pc[i]   <= '0;
            end
        end else if (redirect) begin
            pc    <= redirect_addr;
            count <= '0;
        end else begin
            if (fetch_fire_c) begin
                pc <= pc + ADDR_W'(1);
            end
            count    <= count + CNT_W'(fetch_fire_c) - CNT_W'(pop_c);
            buf_data <= nxt_data;
            buf_pc   <= nxt_pc;
        end
    end

endmodule

// File: tb/tb_instr_fetch.sv
// Directed bench for instr_fetch: reset, steady fetch, backpressure, redirect, wrap, mid-handshake reset.
// Expectations follow the FIFO depth selected by FETCH_PREFETCH_EN.
module tb_instr_fetch;
    localparam int unsigned ADDR_W = 16;
    localparam int unsigned DATA_W = 16;
`ifdef FETCH_PREFETCH_EN
    localparam int unsigned D = 2;
`else
    localparam int unsigned D = 1;
`endif

    logic              CLK = 1'b0;
    logic              reset;
    logic [ADDR_W-1:0] pc_reset_address;
    logic              redirect;
    logic [ADDR_W-1:0] redirect_addr;
    logic [ADDR_W-1:0] pc;

    int n_tests = 0;
    int n_fail  = 0;

    instr_fetch_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

    // Memory model: every word is its address xor 0xA5A5.
    assign bus.mem_rdata = bus.mem_addr ^ 16'hA5A5;

    instr_fetch #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
        .CLK              (CLK),
        .reset            (reset),
        .pc_reset_address (pc_reset_address),
        .redirect         (redirect),
        .redirect_addr    (redirect_addr),
        .bus              (bus),
        .pc               (pc)
    );

    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    function automatic logic [15:0] word(input logic [15:0] a);
        return a ^ 16'hA5A5;
    endfunction

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [15:0] steady_pc;
        logic [15:0] bp_head;
        logic [15:0] bp_pc;
        logic        exp_v;
        logic [15:0] exp_pc;

        steady_pc = (D == 2) ? 16'h0106 : 16'h0103;
        bp_head   = (D == 2) ? 16'h0105 : 16'h0103;
        bp_pc     = (D == 2) ? 16'h0107 : 16'h0104;

        // Reset
        reset            = 1'b1;
        pc_reset_address = 16'h0100;
        redirect         = 1'b0;
        redirect_addr    = 16'h0000;
        bus.mem_ack      = 1'b0;
        bus.instr_ready  = 1'b0;
        tick();
        tick();
        check("rst_pc",       32'(pc),              32'h0100);
        check("rst_mem_req",  32'(bus.mem_req),     32'd0);
        check("rst_valid",    32'(bus.instr_valid), 32'd0);
        check("rst_instr",    32'(bus.instr),       32'h0000);
        check("rst_instr_pc", 32'(bus.instr_pc),    32'h0000);
        reset = 1'b0;
        tick();
        check("rel_mem_req",  32'(bus.mem_req),     32'd1);
        check("rel_mem_addr", 32'(bus.mem_addr),    32'h0100);
        check("rel_valid",    32'(bus.instr_valid), 32'd0);

        // Steady fetch at full consumer rate
        bus.mem_ack     = 1'b1;
        bus.instr_ready = 1'b1;
        for (int k = 1; k <= 6; k++) begin
            tick();
            exp_v  = (D == 2) ? 1'b1 : ((k % 2) == 1);
            exp_pc = (D == 2) ? 16'(16'h0100 + k - 1) : 16'(16'h0100 + (k - 1) / 2);
            check("steady_valid", 32'(bus.instr_valid), 32'(exp_v));
            if (exp_v) begin
                check("steady_instr_pc", 32'(bus.instr_pc), 32'(exp_pc));
                check("steady_instr",    32'(bus.instr),    32'(word(exp_pc)));
            end
        end
        check("steady_pc", 32'(pc), 32'(steady_pc));

        // Backpressure: consumer stalls for 5 cycles
        bus.instr_ready = 1'b0;
        for (int k = 1; k <= 5; k++) begin
            tick();
            check("bp_valid",    32'(bus.instr_valid), 32'd1);
            check("bp_instr_pc", 32'(bus.instr_pc),    32'(bp_head));
            check("bp_instr",    32'(bus.instr),       32'(word(bp_head)));
        end
        check("bp_mem_req", 32'(bus.mem_req), 32'd0);
        check("bp_pc",      32'(pc),          32'(bp_pc));
        bus.mem_ack     = 1'b0;
        bus.instr_ready = 1'b1;
        for (int j = 1; j < int'(D); j++) begin
            tick();
            check("drain_valid",    32'(bus.instr_valid), 32'd1);
            check("drain_instr_pc", 32'(bus.instr_pc),    32'(16'(bp_head + j)));
        end
        tick();
        check("drain_empty", 32'(bus.instr_valid), 32'd0);
        check("drain_pc",    32'(pc),              32'(bp_pc));

        // Redirect in the same cycle as an ack
        redirect      = 1'b1;
        redirect_addr = 16'h2000;
        bus.mem_ack   = 1'b1;
        check("redir_req_pre", 32'(bus.mem_req), 32'd1);
        tick();
        redirect = 1'b0;
        check("redir_valid",    32'(bus.instr_valid), 32'd0);
        check("redir_pc",       32'(pc),              32'h2000);
        check("redir_mem_addr", 32'(bus.mem_addr),    32'h2000);
        tick();
        check("redir_first_valid", 32'(bus.instr_valid), 32'd1);
        check("redir_first_pc",    32'(bus.instr_pc),    32'h2000);
        check("redir_first_instr", 32'(bus.instr),       32'(word(16'h2000)));
        bus.mem_ack = 1'b0;
        tick();
        check("redir_drain", 32'(bus.instr_valid), 32'd0);
        check("redir_pc2",   32'(pc),              32'h2001);

        // PC wrap at the top of the address space
        reset            = 1'b1;
        pc_reset_address = 16'hFFFF;
        tick();
        reset       = 1'b0;
        bus.mem_ack = 1'b1;
        tick();
        check("wrap_first_valid", 32'(bus.instr_valid), 32'd1);
        check("wrap_first_pc",    32'(bus.instr_pc),    32'hFFFF);
        if (D == 1) tick();
        tick();
        bus.mem_ack = 1'b0;
        check("wrap_second_valid", 32'(bus.instr_valid), 32'd1);
        check("wrap_second_pc",    32'(bus.instr_pc),    32'h0000);
        check("wrap_pc",           32'(pc),              32'h0001);

        // Reset while the consumer is stalling on a valid head
        bus.instr_ready = 1'b0;
        tick();
        check("mh_pre_valid", 32'(bus.instr_valid), 32'd1);
        pc_reset_address = 16'h0300;
        reset            = 1'b1;
        #1;
        check("mh_comb_valid", 32'(bus.instr_valid), 32'd0);
        check("mh_comb_req",   32'(bus.mem_req),     32'd0);
        tick();
        check("mh_valid",    32'(bus.instr_valid), 32'd0);
        check("mh_pc",       32'(pc),              32'h0300);
        check("mh_instr",    32'(bus.instr),       32'h0000);
        check("mh_instr_pc", 32'(bus.instr_pc),    32'h0000);
        reset = 1'b0;
        tick();
        check("mh_rel_req",  32'(bus.mem_req),  32'd1);
        check("mh_rel_addr", 32'(bus.mem_addr), 32'h0300);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
